// File: rtl/imgproc_mode_pkg.sv
// imgproc_mode_pkg
// Shared types and constants for the image-processing mode scheduler:
// FSM state encoding, request source encoding, Avalon register map,
// STATUS/CTRL bit positions and the STATUS word packing helper.
package imgproc_mode_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef enum logic {
        SRC_SW   = 1'b0,
        SRC_HOST = 1'b1
    } src_e;

    localparam logic [1:0] REG_CTRL        = 2'd0;
    localparam logic [1:0] REG_MODE_REQ    = 2'd1;
    localparam logic [1:0] REG_STATUS      = 2'd2;
    localparam logic [1:0] REG_FRAME_COUNT = 2'd3;

    localparam int unsigned CTRL_HOST_LOCK  = 0;
    localparam int unsigned CTRL_IMMEDIATE  = 1;

    localparam int unsigned STATUS_MODE_LSB   = 0;
    localparam int unsigned STATUS_PEND_LSB   = 3;
    localparam int unsigned STATUS_PEND_VALID = 6;
    localparam int unsigned STATUS_TIMEOUT    = 7;
    localparam int unsigned STATUS_SRC        = 8;

    // Assemble the STATUS read word from its individual fields.
    function automatic logic [31:0] pack_status(
        input logic [MODE_W-1:0] mode_cur,
        input logic [MODE_W-1:0] mode_pend,
        input logic              pend_valid,
        input logic              timeout,
        input src_e              src
    );
        logic [31:0] s;
        s = 32'd0;
        s[STATUS_MODE_LSB +: MODE_W] = mode_cur;
        s[STATUS_PEND_LSB +: MODE_W] = mode_pend;
        s[STATUS_PEND_VALID]         = pend_valid;
        s[STATUS_TIMEOUT]            = timeout;
        s[STATUS_SRC]                = src;
        return s;
    endfunction

endpackage

// File: rtl/mode_sw_debounce.sv
// mode_sw_debounce
// Debounces the (already synchronised) board switch mode and emits a
// one-cycle request when a new stable value differs from the last one
// accepted.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sw_mode [2:0]   switch mode select
//   req             one-cycle request strobe (registered)
//   req_mode [2:0]  mode carried with req (registered)
module mode_sw_debounce
    import imgproc_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] sw_mode,
    output logic              req,
    output logic [MODE_W-1:0] req_mode
);

    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [MODE_W-1:0] prev_q, prev_d;
    logic [MODE_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [MODE_W-1:0] req_mode_q, req_mode_d;

    // Stability counter; it saturates, so the reference compare is what
    // keeps a long-stable value from re-requesting.
    always_comb begin
        prev_d     = sw_mode;
        ref_d      = ref_q;
        cnt_d      = cnt_q;
        req_d      = 1'b0;
        req_mode_d = req_mode_q;
        if (sw_mode != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (sw_mode != ref_q) begin
            req_d      = 1'b1;
            req_mode_d = sw_mode;
            ref_d      = sw_mode;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; the reference tracks the live switches at reset so
    // that reset by itself never produces a request.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= sw_mode;
            ref_q      <= sw_mode;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            req_mode_q <= '0;
        end else begin
            prev_q     <= prev_d;
            ref_q      <= ref_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            req_mode_q <= req_mode_d;
        end
    end

    assign req      = req_q;
    assign req_mode = req_mode_q;

endmodule

// File: rtl/imgproc_mode_scheduler.sv
// imgproc_mode_scheduler
// Arbitrates host (Avalon-MM) and switch mode requests for the image core
// and commits the granted mode only on a frame boundary (fval falling),
// on an immediate request, or when the watchdog expires.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   avs_address/write/writedata/read Avalon-MM slave, 4 registers
//   avs_readdata                     read data, valid 1 cycle after avs_read
//   sw_mode [2:0]                    switch mode select (synchronised)
//   fval                             camera frame valid (synchronised)
//   mode_out [2:0]                   committed mode to the core
//   mode_pending                     a request is waiting for commit
//   commit_pulse                     one-cycle strobe when mode_out updates
module imgproc_mode_scheduler
    import imgproc_mode_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       TIMEOUT_CYCLES  = 5000000,
    parameter logic [MODE_W-1:0] RESET_MODE      = 3'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic [MODE_W-1:0] sw_mode,
    input  logic              fval,
    output logic [MODE_W-1:0] mode_out,
    output logic              mode_pending,
    output logic              commit_pulse
);

    localparam int unsigned   WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    logic              dbnc_req_s;
    logic [MODE_W-1:0] dbnc_mode_s;
    logic              host_req_s, sw_req_s, frame_edge_s, load_s;
    logic              slot_valid_s;
    logic [MODE_W-1:0] slot_mode_s;
    src_e              slot_src_s;
    logic              wdata_unused_s;

    state_e            state_q, state_d;
    logic              slot_valid_q, slot_valid_d;
    logic [MODE_W-1:0] slot_mode_q, slot_mode_d;
    src_e              slot_src_q, slot_src_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    src_e              last_src_q, last_src_d;
    logic              host_lock_q, host_lock_d;
    logic              immediate_q, immediate_d;
    logic [MODE_W-1:0] mode_out_q, mode_out_d;
    logic              commit_pulse_q, commit_pulse_d;
    logic              mode_pending_q, mode_pending_d;
    logic              fval_q, fval_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [31:0]       readdata_q, readdata_d;

    mode_sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk     (clk),
        .reset   (reset),
        .sw_mode (sw_mode),
        .req     (dbnc_req_s),
        .req_mode(dbnc_mode_s)
    );

    assign wdata_unused_s = ^{avs_writedata[31:8], avs_writedata[6:3]};

    // Request decode, slot arbitration, FSM and register writes.
    always_comb begin
        host_req_s   = avs_write && (avs_address == REG_MODE_REQ);
        sw_req_s     = dbnc_req_s && !host_lock_q;
        frame_edge_s = fval_q && !fval;

        state_d        = state_q;
        wd_d           = wd_q;
        timeout_d      = timeout_q;
        last_src_d     = last_src_q;
        host_lock_d    = host_lock_q;
        immediate_d    = immediate_q;
        mode_out_d     = mode_out_q;
        commit_pulse_d = 1'b0;
        fval_d         = fval;
        frame_cnt_d    = frame_edge_s ? frame_cnt_q + 16'd1 : frame_cnt_q;

        if (avs_write && (avs_address == REG_CTRL)) begin
            host_lock_d = avs_writedata[CTRL_HOST_LOCK];
            immediate_d = avs_writedata[CTRL_IMMEDIATE];
        end else begin
            host_lock_d = host_lock_q;
        end
        // Clear first so a watchdog expiry in the same cycle still sets it.
        if (avs_write && (avs_address == REG_STATUS) && avs_writedata[STATUS_TIMEOUT]) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end

        // Commit empties the slot before arbitration, so a request arriving
        // in COMMIT is captured into a fresh slot.
        slot_valid_s = slot_valid_q;
        slot_mode_s  = slot_mode_q;
        slot_src_s   = slot_src_q;
        if (state_q == COMMIT) begin
            mode_out_d     = slot_mode_q;
            commit_pulse_d = 1'b1;
            last_src_d     = slot_src_q;
            slot_valid_s   = 1'b0;
            slot_mode_s    = '0;
            slot_src_s     = SRC_SW;
        end else begin
            mode_out_d = mode_out_q;
        end

        // Host always wins; the switch may only replace its own request.
        load_s = 1'b0;
        if (host_req_s) begin
            load_s       = 1'b1;
            slot_valid_s = 1'b1;
            slot_mode_s  = avs_writedata[MODE_W-1:0];
            slot_src_s   = SRC_HOST;
        end else if (sw_req_s && (!slot_valid_s || (slot_src_s == SRC_SW))) begin
            load_s       = 1'b1;
            slot_valid_s = 1'b1;
            slot_mode_s  = dbnc_mode_s;
            slot_src_s   = SRC_SW;
        end else begin
            load_s = 1'b0;
        end
        slot_valid_d = slot_valid_s;
        slot_mode_d  = slot_mode_s;
        slot_src_d   = slot_src_s;

        case (state_q)
            IDLE: begin
                if (load_s) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (frame_edge_s || immediate_q) begin
                    state_d = COMMIT;
                end else if (wd_q == WD_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = COMMIT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            COMMIT: begin
                if (load_s) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                slot_valid_d = 1'b0;
            end
        endcase

        mode_pending_d = (state_d != IDLE);
    end

    // Read mux, registered so data appears one cycle after avs_read.
    always_comb begin
        readdata_d = 32'd0;
        if (avs_read) begin
            case (avs_address)
                REG_CTRL:        readdata_d = {30'd0, immediate_q, host_lock_q};
                REG_MODE_REQ:    readdata_d = {29'd0, slot_mode_q};
                REG_STATUS:      readdata_d = pack_status(mode_out_q, slot_mode_q, slot_valid_q,
                                                          timeout_q, last_src_q);
                REG_FRAME_COUNT: readdata_d = {16'd0, frame_cnt_q};
                default:         readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = 32'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            slot_valid_q   <= 1'b0;
            slot_mode_q    <= '0;
            slot_src_q     <= SRC_SW;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
            last_src_q     <= SRC_SW;
            host_lock_q    <= 1'b0;
            immediate_q    <= 1'b0;
            mode_out_q     <= RESET_MODE;
            commit_pulse_q <= 1'b0;
            mode_pending_q <= 1'b0;
            fval_q         <= 1'b0;
            frame_cnt_q    <= 16'd0;
            readdata_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            slot_valid_q   <= slot_valid_d;
            slot_mode_q    <= slot_mode_d;
            slot_src_q     <= slot_src_d;
            wd_q           <= wd_d;
            timeout_q      <= timeout_d;
            last_src_q     <= last_src_d;
            host_lock_q    <= host_lock_d;
            immediate_q    <= immediate_d;
            mode_out_q     <= mode_out_d;
            commit_pulse_q <= commit_pulse_d;
            mode_pending_q <= mode_pending_d;
            fval_q         <= fval_d;
            frame_cnt_q    <= frame_cnt_d;
            readdata_q     <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign mode_out     = mode_out_q;
    assign mode_pending = mode_pending_q;
    assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_imgproc_mode_scheduler.sv
// Directed bench for imgproc_mode_scheduler with a behavioural reference
// model checked every cycle, plus hand-computed literal checks.
module tb_imgproc_mode_scheduler;

    localparam int DEB = 8;
    localparam int TO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [2:0]  sw_mode;
    logic        fval;
    logic [2:0]  mode_out;
    logic        mode_pending;
    logic        commit_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imgproc_mode_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .RESET_MODE     (3'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .sw_mode      (sw_mode),
        .fval         (fval),
        .mode_out     (mode_out),
        .mode_pending (mode_pending),
        .commit_pulse (commit_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_mode, m_pend_mode, m_pend_src, m_last_src, m_age, m_frames, m_rd;
    bit   m_pend_valid, m_commit_next, m_timeout, m_lock, m_imm, m_fval_prev, m_pulse;
    bit   m_ready = 1'b0;
    logic [2:0] sw_prev, sw_ref, sw_fire_mode;
    int   sw_run;
    bit   sw_fire;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0; m_pend_mode = 0; m_pend_src = 0; m_last_src = 0;
                m_age = 0; m_frames = 0; m_rd = 0;
                m_pend_valid = 0; m_commit_next = 0; m_timeout = 0;
                m_lock = 0; m_imm = 0; m_fval_prev = 0; m_pulse = 0;
                sw_prev = sw_mode; sw_ref = sw_mode; sw_run = 0; sw_fire = 0;
                sw_fire_mode = 3'd0;
                m_ready = 1'b1;
            end else begin
                bit hreq, sreq, fedge, waiting, go, loaded;
                int rd;
                rd = 0;
                if (avs_read) begin
                    case (avs_address)
                        2'd0: rd = m_lock + 2 * m_imm;
                        2'd1: rd = m_pend_mode;
                        2'd2: rd = m_mode + 8 * m_pend_mode + 64 * m_pend_valid
                                   + 128 * m_timeout + 256 * m_last_src;
                        default: rd = m_frames;
                    endcase
                end
                hreq    = avs_write && (avs_address == 2'd1);
                sreq    = sw_fire && !m_lock;
                fedge   = m_fval_prev && !fval;
                waiting = m_pend_valid && !m_commit_next;
                m_pulse = 0;
                if (m_commit_next) begin
                    m_mode = m_pend_mode; m_last_src = m_pend_src;
                    m_pend_valid = 0; m_pend_mode = 0; m_pend_src = 0;
                    m_pulse = 1;
                end
                loaded = 0;
                if (hreq) begin
                    m_pend_valid = 1; m_pend_mode = int'(avs_writedata[2:0]); m_pend_src = 1; loaded = 1;
                end else if (sreq && (!m_pend_valid || m_pend_src == 0)) begin
                    m_pend_valid = 1; m_pend_mode = int'(sw_fire_mode); m_pend_src = 0; loaded = 1;
                end
                if (avs_write && avs_address == 2'd2 && avs_writedata[7]) m_timeout = 0;
                go = 0;
                if (waiting) begin
                    if (fedge || m_imm) go = 1;
                    else if (m_age == TO - 1) begin go = 1; m_timeout = 1; end
                    else m_age++;
                end else if (loaded) begin
                    m_age = 0;
                end
                m_commit_next = go;
                if (avs_write && avs_address == 2'd0) begin
                    m_lock = avs_writedata[0]; m_imm = avs_writedata[1];
                end
                if (fedge) m_frames = (m_frames + 1) % 65536;
                m_fval_prev = fval;
                sw_fire = 0;
                if (sw_mode == sw_prev) begin
                    if (sw_run >= DEB - 1 && sw_mode != sw_ref) begin
                        sw_fire = 1; sw_fire_mode = sw_mode; sw_ref = sw_mode;
                    end
                    sw_run++;
                end else begin
                    sw_run = 0;
                end
                sw_prev = sw_mode;
                m_rd = rd;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                chk("mode_out", {29'd0, mode_out}, m_mode);
                chk("mode_pending", {31'd0, mode_pending}, {31'd0, (m_pend_valid || m_commit_next)});
                chk("commit_pulse", {31'd0, commit_pulse}, {31'd0, m_pulse});
                chk("avs_readdata", avs_readdata, m_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; avs_address = 2'd0; avs_write = 1'b0; avs_writedata = 32'd0;
        avs_read = 1'b0; sw_mode = 3'd0; fval = 1'b0;
        tick(3);
        reset = 1'b0;
        chk("rst_mode", {29'd0, mode_out}, 32'd0);
        chk("rst_pending", {31'd0, mode_pending}, 32'd0);
        chk("rst_pulse", {31'd0, commit_pulse}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);

        // Host request committed on a frame edge.
        fval = 1'b1;
        tick(2);
        avs_wr(2'd1, 32'd5);
        tick(19);
        fval = 1'b0;
        tick(1);
        chk("t1_pre_mode", {29'd0, mode_out}, 32'd0);
        chk("t1_pre_pending", {31'd0, mode_pending}, 32'd1);
        tick(1);
        chk("t1_mode", {29'd0, mode_out}, 32'd5);
        chk("t1_pulse", {31'd0, commit_pulse}, 32'd1);
        tick(1);
        chk("t1_pulse_end", {31'd0, commit_pulse}, 32'd0);
        avs_rd(2'd2, r);
        chk("t1_status", r, 32'h105);
        avs_rd(2'd3, r);
        chk("t1_frames", r, 32'd1);

        // Immediate commit without fval activity.
        avs_wr(2'd0, 32'h2);
        avs_wr(2'd1, 32'd3);
        tick(1);
        chk("t2_mode_wait", {29'd0, mode_out}, 32'd5);
        tick(1);
        chk("t2_mode", {29'd0, mode_out}, 32'd3);
        avs_wr(2'd0, 32'h0);

        // Debounced switch request, committed on a frame edge.
        sw_mode = 3'd6;
        for (int i = 0; i < 8; i++) begin
            fval = 1'b1; tick(3);
            fval = 1'b0; tick(3);
        end
        chk("t3_mode", {29'd0, mode_out}, 32'd6);
        avs_rd(2'd2, r);
        chk("t3_status", r, 32'h006);
        sw_mode = 3'd3; tick(3);
        sw_mode = 3'd6; tick(20);
        chk("t3_glitch_mode", {29'd0, mode_out}, 32'd6);
        chk("t3_glitch_pending", {31'd0, mode_pending}, 32'd0);
        avs_rd(2'd3, r);
        chk("t3_frames", r, 32'd9);

        // Host overrides a pending switch request; a concurrent switch change is dropped.
        sw_mode = 3'd1; tick(12);
        chk("t4_sw_pending", {31'd0, mode_pending}, 32'd1);
        sw_mode = 3'd7;
        avs_wr(2'd1, 32'd2);
        tick(12);
        avs_rd(2'd1, r);
        chk("t4_pend_mode", r, 32'd2);
        fval = 1'b1; tick(2);
        fval = 1'b0; tick(2);
        chk("t4_mode", {29'd0, mode_out}, 32'd2);
        avs_rd(2'd2, r);
        chk("t4_status", r, 32'h102);
        avs_wr(2'd0, 32'h1);
        sw_mode = 3'd4; tick(20);
        chk("t4_lock_pending", {31'd0, mode_pending}, 32'd0);
        chk("t4_lock_mode", {29'd0, mode_out}, 32'd2);
        avs_wr(2'd0, 32'h0);
        tick(12);
        chk("t4_unlock_pending", {31'd0, mode_pending}, 32'd0);

        // Watchdog forced commit with fval held low.
        avs_wr(2'd1, 32'd1);
        tick(64);
        chk("t5_pre_mode", {29'd0, mode_out}, 32'd2);
        chk("t5_pre_pending", {31'd0, mode_pending}, 32'd1);
        tick(1);
        chk("t5_mode", {29'd0, mode_out}, 32'd1);
        chk("t5_pulse", {31'd0, commit_pulse}, 32'd1);
        avs_rd(2'd2, r);
        chk("t5_status", r, 32'h181);
        avs_wr(2'd2, 32'h80);
        avs_rd(2'd2, r);
        chk("t5_status_clr", r, 32'h101);

        // Reset in the middle of a wait discards the request.
        avs_wr(2'd1, 32'd5);
        tick(10);
        chk("t6_pending", {31'd0, mode_pending}, 32'd1);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        chk("t6_rst_mode", {29'd0, mode_out}, 32'd0);
        chk("t6_rst_pending", {31'd0, mode_pending}, 32'd0);
        tick(80);
        chk("t6_after_mode", {29'd0, mode_out}, 32'd0);
        chk("t6_after_pending", {31'd0, mode_pending}, 32'd0);
        avs_rd(2'd2, r);
        chk("t6_status", r, 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
